// File: rtl/rcu_pkg.sv
// Shared definitions for the APB4 reset and clock control unit: register
// offsets, STAT bit positions, default widths, the CTRL field layout and a
// byte-strobe mask helper.
package rcu_pkg;

  localparam int RCU_NUM_PERIPH_DEF = 8;
  localparam int RCU_DIV_WIDTH_DEF  = 16;
  localparam int RCU_PW_WIDTH       = 8;
  localparam int STAT_WIDTH         = 4;

  // Byte offsets; only paddr[4:2] is decoded, so offsets are 5 bits wide.
  localparam logic [4:0] RCU_CTRL    = 5'h00;
  localparam logic [4:0] RCU_CLKEN   = 5'h04;
  localparam logic [4:0] RCU_RSTHOLD = 5'h08;
  localparam logic [4:0] RCU_DIV     = 5'h0C;
  localparam logic [4:0] RCU_STAT    = 5'h10;

  // Reset-cause bits in STAT.
  localparam int STAT_POR = 0;
  localparam int STAT_EXT = 1;
  localparam int STAT_WDT = 2;
  localparam int STAT_SW  = 3;

  typedef struct packed {
    logic [15:0]             rsvd_hi;
    logic [RCU_PW_WIDTH-1:0] pw;
    logic [6:0]              rsvd_lo;
    logic                    swrst;
  } rcu_ctrl_t;

  // Expand the four byte strobes into a 32-bit write mask.
  function automatic logic [31:0] rcu_byte_mask(input logic [3:0] strb);
    logic [31:0] mask;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/rcu_rst_gen.sv
// Reset pulse generator: registers the external and watchdog requests once,
// detects their rising edges, and stretches any trigger (including software)
// into a sys_rst pulse of max(PW,1) cycles. A new trigger reloads the counter.
module rcu_rst_gen import rcu_pkg::*; (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_ext_req,
  input  logic                    i_wdt_req,
  input  logic                    i_sw_trig,
  input  logic [RCU_PW_WIDTH-1:0] i_pw,
  output logic                    o_ext_trig,
  output logic                    o_wdt_trig,
  output logic                    o_sys_rst
);

  logic                    r_ext_s;
  logic                    r_ext_d;
  logic                    r_wdt_s;
  logic                    r_wdt_d;
  logic [RCU_PW_WIDTH-1:0] r_cnt;
  logic [RCU_PW_WIDTH-1:0] w_load;
  logic                    w_any_trig;

  // Sample requests and keep the previous sample for rising-edge detection
  always_ff @(posedge clk_i) begin
    // NOTE: flops use non-blocking assignments so r_*_d sees r_*_s from before this edge.
    if (rst_i) begin
      r_ext_s <= 1'b0;
      r_ext_d <= 1'b0;
      r_wdt_s <= 1'b0;
      r_wdt_d <= 1'b0;
    end else begin
      r_ext_s <= i_ext_req;
      r_ext_d <= r_ext_s;
      r_wdt_s <= i_wdt_req;
      r_wdt_d <= r_wdt_s;
    end
  end

  assign o_ext_trig = r_ext_s & ~r_ext_d;
  assign o_wdt_trig = r_wdt_s & ~r_wdt_d;
  assign w_any_trig = o_ext_trig | o_wdt_trig | i_sw_trig;
  assign w_load     = (i_pw == '0) ? RCU_PW_WIDTH'(1) : i_pw;

  // Pulse counter: load on any trigger, otherwise count down to zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_any_trig) begin
      r_cnt <= w_load;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - RCU_PW_WIDTH'(1);
    end
  end

  assign o_sys_rst = (r_cnt != '0) & ~rst_i;

endmodule

// File: rtl/apb4_rcu_top.sv
// APB4 reset and clock control unit. Holds CTRL, CLKEN, RSTHOLD, DIV and STAT,
// drives per-peripheral clock enables and resets, and the divided clock-enable
// strobe. Build option RCU_CLKDIV_EN includes the DIV register and divider;
// without it DIV reads 0, ignores writes and clkdiv_en_o is tied high.
module apb4_rcu_top import rcu_pkg::*; #(
  parameter int NUM_PERIPH = RCU_NUM_PERIPH_DEF,
  parameter int DIV_WIDTH  = RCU_DIV_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           paddr_i,
  input  logic [2:0]            pprot_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic                  pready_o,
  output logic [31:0]           prdata_o,
  output logic                  pslverr_o,
  input  logic                  ext_rst_req_i,
  input  logic                  wdt_rst_req_i,
  output logic                  sys_rst_o,
  output logic [NUM_PERIPH-1:0] clk_en_o,
  output logic [NUM_PERIPH-1:0] periph_rst_o,
  output logic                  clkdiv_en_o
);

  logic                    w_access;
  logic                    w_wr;
  logic [4:0]              w_off;
  logic                    w_valid;
  logic [31:0]             w_mask;
  rcu_ctrl_t               w_ctrl_wdata;
  rcu_ctrl_t               w_ctrl_rdata;
  logic                    w_wr_ctrl;
  logic                    w_wr_clken;
  logic                    w_wr_rsthold;
  logic                    w_wr_div;
  logic                    w_wr_stat;
  logic                    w_sw_trig;
  logic                    w_ext_trig;
  logic                    w_wdt_trig;
  logic [RCU_PW_WIDTH-1:0] w_pw_eff;
  logic [STAT_WIDTH-1:0]   w_stat_set;
  logic [STAT_WIDTH-1:0]   w_stat_clr;
  logic [31:0]             w_div_rd;
  logic [31:0]             w_rdata;
  logic                    w_unused;

  logic [RCU_PW_WIDTH-1:0] r_ctrl_pw;
  logic [NUM_PERIPH-1:0]   r_clken;
  logic [NUM_PERIPH-1:0]   r_rsthold;
  logic [STAT_WIDTH-1:0]   r_stat;

  assign w_access     = psel_i & penable_i;
  assign w_wr         = w_access & pwrite_i;
  assign w_off        = {paddr_i[4:2], 2'b00};
  assign w_valid      = (paddr_i[4:2] <= 3'd4);
  assign w_mask       = rcu_byte_mask(pstrb_i);
  assign w_ctrl_wdata = pwdata_i;

  assign w_wr_ctrl    = w_wr & (w_off == RCU_CTRL);
  assign w_wr_clken   = w_wr & (w_off == RCU_CLKEN);
  assign w_wr_rsthold = w_wr & (w_off == RCU_RSTHOLD);
  assign w_wr_div     = w_wr & (w_off == RCU_DIV);
  assign w_wr_stat    = w_wr & (w_off == RCU_STAT);

  // A CTRL write that sets PW and SWRST together uses the new PW for its pulse.
  assign w_sw_trig = w_wr_ctrl & pstrb_i[0] & w_ctrl_wdata.swrst;
  assign w_pw_eff  = (w_wr_ctrl & pstrb_i[1]) ? w_ctrl_wdata.pw : r_ctrl_pw;

  rcu_rst_gen u_rst_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_ext_req  (ext_rst_req_i),
    .i_wdt_req  (wdt_rst_req_i),
    .i_sw_trig  (w_sw_trig),
    .i_pw       (w_pw_eff),
    .o_ext_trig (w_ext_trig),
    .o_wdt_trig (w_wdt_trig),
    .o_sys_rst  (sys_rst_o)
  );

  // Collect the reset causes seen this cycle and the W1C clear mask
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_stat_set           = '0;
    w_stat_set[STAT_EXT] = w_ext_trig;
    w_stat_set[STAT_WDT] = w_wdt_trig;
    w_stat_set[STAT_SW]  = w_sw_trig;
    w_stat_clr           = (w_wr_stat & pstrb_i[0]) ? pwdata_i[STAT_WIDTH-1:0] : '0;
  end

  // Control and status registers; only rst_i clears them, never sys_rst_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl_pw         <= '0;
      r_clken           <= '0;
      r_rsthold         <= '1;
      r_stat            <= '0;
      r_stat[STAT_POR]  <= 1'b1;
    end else begin
      r_ctrl_pw <= w_pw_eff;
      if (w_wr_clken) begin
        r_clken <= (r_clken & ~w_mask[NUM_PERIPH-1:0]) |
                   (pwdata_i[NUM_PERIPH-1:0] & w_mask[NUM_PERIPH-1:0]);
      end
      if (w_wr_rsthold) begin
        r_rsthold <= (r_rsthold & ~w_mask[NUM_PERIPH-1:0]) |
                     (pwdata_i[NUM_PERIPH-1:0] & w_mask[NUM_PERIPH-1:0]);
      end
      // A cause raised this cycle wins over a clear of the same bit.
      r_stat <= (r_stat & ~w_stat_clr) | w_stat_set;
    end
  end

`ifdef RCU_CLKDIV_EN
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 w_div_hit;

  assign w_div_hit = (r_div_cnt == r_div);

  // DIV register and the 0..DIV wrapping counter; a DIV write restarts the count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_div     <= '0;
      r_div_cnt <= '0;
    end else if (w_wr_div) begin
      r_div     <= (r_div & ~w_mask[DIV_WIDTH-1:0]) |
                   (pwdata_i[DIV_WIDTH-1:0] & w_mask[DIV_WIDTH-1:0]);
      r_div_cnt <= '0;
    end else if (w_div_hit) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

  assign clkdiv_en_o = w_div_hit & ~rst_i;
  assign w_div_rd    = 32'(r_div);
`else
  assign clkdiv_en_o = 1'b1;
  assign w_div_rd    = '0;
`endif

  // Read mux; CTRL.SWRST always reads back as 0
  always_comb begin
    w_ctrl_rdata    = '0;
    w_ctrl_rdata.pw = r_ctrl_pw;
    w_rdata         = '0;
    case (w_off)
      RCU_CTRL:    w_rdata = w_ctrl_rdata;
      RCU_CLKEN:   w_rdata = 32'(r_clken);
      RCU_RSTHOLD: w_rdata = 32'(r_rsthold);
      RCU_DIV:     w_rdata = w_div_rd;
      RCU_STAT:    w_rdata = 32'(r_stat);
      default:     w_rdata = '0;
    endcase
  end

  assign pready_o  = 1'b1;
  assign prdata_o  = (psel_i & ~pwrite_i & ~rst_i) ? w_rdata : '0;
  assign pslverr_o = w_access & ~w_valid & ~rst_i;

  assign periph_rst_o = rst_i ? '1 : (r_rsthold | {NUM_PERIPH{sys_rst_o}});
  assign clk_en_o     = r_clken & ~periph_rst_o;

  // Bits of the bus that carry no function here.
  assign w_unused = ^{pprot_i, paddr_i, pwdata_i, w_mask, w_ctrl_wdata, w_wr_div};

endmodule

// File: tb/tb_apb4_rcu_top.sv
// Self-checking bench for apb4_rcu_top: directed scenarios followed by random
// APB traffic and request toggling, all compared cycle by cycle against a
// behavioural model that tracks pulse end times and divider phase.
module tb_apb4_rcu_top;

  localparam int NP = 8;
`ifdef RCU_CLKDIV_EN
  localparam bit HAS_DIV = 1'b1;
`else
  localparam bit HAS_DIV = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   paddr_i;
  logic [2:0]    pprot_i;
  logic          psel_i, penable_i, pwrite_i;
  logic [31:0]   pwdata_i;
  logic [3:0]    pstrb_i;
  logic          pready_o;
  logic [31:0]   prdata_o;
  logic          pslverr_o;
  logic          ext_rst_req_i, wdt_rst_req_i;
  logic          sys_rst_o;
  logic [NP-1:0] clk_en_o, periph_rst_o;
  logic          clkdiv_en_o;

  apb4_rcu_top #(.NUM_PERIPH(NP), .DIV_WIDTH(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .paddr_i(paddr_i), .pprot_i(pprot_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .pwdata_i(pwdata_i), .pstrb_i(pstrb_i), .pready_o(pready_o),
    .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .ext_rst_req_i(ext_rst_req_i), .wdt_rst_req_i(wdt_rst_req_i),
    .sys_rst_o(sys_rst_o), .clk_en_o(clk_en_o), .periph_rst_o(periph_rst_o),
    .clkdiv_en_o(clkdiv_en_o)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [31:0] m_edge = 0;      // number of rising edges seen
  logic [31:0] m_rst_end = 0;   // sys_rst is high while m_edge < m_rst_end
  logic [31:0] m_div_base = 0;  // edge at which the divider phase restarted
  logic [31:0] m_pw, m_clken, m_rsthold, m_div, m_stat;
  logic        m_ext_h1, m_ext_h2, m_wdt_h1, m_wdt_h2; // requests one/two edges ago

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (st[b]) r = (r & ~(32'hFF << (8*b))) | (wd & (32'hFF << (8*b)));
    return r;
  endfunction

  task automatic model_edge();
    logic        wr, sw, ext_t, wdt_t;
    logic [2:0]  idx;
    logic [31:0] pw_eff, clr, set;
    m_edge++;
    if (rst_i) begin
      m_pw = 0; m_clken = 0; m_rsthold = 32'hFF; m_div = 0; m_stat = 32'h1;
      m_rst_end = m_edge; m_div_base = m_edge;
      m_ext_h1 = 0; m_ext_h2 = 0; m_wdt_h1 = 0; m_wdt_h2 = 0;
      return;
    end
    wr     = psel_i && penable_i && pwrite_i;
    idx    = paddr_i[4:2];
    sw     = wr && idx == 3'd0 && pstrb_i[0] && pwdata_i[0];
    pw_eff = (wr && idx == 3'd0 && pstrb_i[1]) ? {24'b0, pwdata_i[15:8]} : m_pw;
    ext_t  = m_ext_h1 && !m_ext_h2;
    wdt_t  = m_wdt_h1 && !m_wdt_h2;
    m_ext_h2 = m_ext_h1; m_ext_h1 = ext_rst_req_i;
    m_wdt_h2 = m_wdt_h1; m_wdt_h1 = wdt_rst_req_i;
    if (ext_t || wdt_t || sw) m_rst_end = m_edge + ((pw_eff == 0) ? 32'd1 : pw_eff);
    clr    = (wr && idx == 3'd4 && pstrb_i[0]) ? (pwdata_i & 32'hF) : 32'h0;
    set    = {28'b0, sw, wdt_t, ext_t, 1'b0};
    m_stat = (m_stat & ~clr) | set;
    m_pw   = pw_eff;
    if (wr && idx == 3'd1) m_clken   = merge(m_clken, pwdata_i, pstrb_i) & 32'hFF;
    if (wr && idx == 3'd2) m_rsthold = merge(m_rsthold, pwdata_i, pstrb_i) & 32'hFF;
    if (HAS_DIV && wr && idx == 3'd3) begin
      m_div      = merge(m_div, pwdata_i, pstrb_i) & 32'hFFFF;
      m_div_base = m_edge;
    end
  endtask

  function automatic logic exp_sys();
    return !rst_i && (m_edge < m_rst_end);
  endfunction

  function automatic logic [NP-1:0] exp_periph();
    if (rst_i) return '1;
    return m_rsthold[NP-1:0] | (exp_sys() ? {NP{1'b1}} : {NP{1'b0}});
  endfunction

  function automatic logic exp_clkdiv();
    if (!HAS_DIV) return 1'b1;
    if (rst_i) return 1'b0;
    if (m_div == 0) return 1'b1;
    return ((m_edge - m_div_base) % (m_div + 1)) == m_div;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] idx);
    case (idx)
      3'd0:    return m_pw << 8;
      3'd1:    return m_clken;
      3'd2:    return m_rsthold;
      3'd3:    return m_div;
      3'd4:    return m_stat;
      default: return 32'h0;
    endcase
  endfunction

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
    check("sys_rst", sys_rst_o, exp_sys());
    check("periph_rst", periph_rst_o, exp_periph());
    check("clk_en", clk_en_o, m_clken[NP-1:0] & ~exp_periph() & {NP{~rst_i}});
    check("clkdiv_en", clkdiv_en_o, exp_clkdiv());
    check("pready", pready_o, 1'b1);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = addr; pwdata_i = data; pstrb_i = strb;
    tick();
    penable_i = 1;
    #1;
    check("wr_pslverr", pslverr_o, addr[4:2] > 3'd4);
    tick();
    psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = addr;
    tick();
    penable_i = 1;
    #1;
    data = prdata_o;
    check($sformatf("rd_data@%02h", addr[7:0]), prdata_o, model_read(addr[4:2]));
    check($sformatf("rd_err@%02h", addr[7:0]), pslverr_o, addr[4:2] > 3'd4);
    tick();
    psel_i = 0; penable_i = 0;
  endtask

  // Count consecutive sys_rst_o high cycles starting with the current one.
  task automatic count_pulse(output int n);
    int guard;
    n = 0; guard = 0;
    while (sys_rst_o === 1'b1 && guard < 400) begin
      n++; guard++;
      tick();
    end
    check("pulse_ended", sys_rst_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] d, a, wd;
    int          n, ones;
    int unsigned op;

    rst_i = 1; paddr_i = 0; pprot_i = 0; psel_i = 0; penable_i = 0; pwrite_i = 0;
    pwdata_i = 0; pstrb_i = 0; ext_rst_req_i = 0; wdt_rst_req_i = 0;
    repeat (3) tick();
    rst_i = 0;
    tick();

    // Reset values
    apb_read(32'h10, d); check("por_stat", d, 32'h1);
    apb_read(32'h04, d); check("rst_clken", d, 32'h0);
    apb_read(32'h08, d); check("rst_rsthold", d, 32'hFF);
    check("rst_periph", periph_rst_o, 8'hFF);
    check("rst_clk_en", clk_en_o, 8'h00);

    // Release peripherals and gate clocks
    apb_write(32'h08, 32'h0, 4'hF);
    apb_write(32'h04, 32'hA5, 4'hF);
    check("periph_released", periph_rst_o, 8'h00);
    check("clk_en_a5", clk_en_o, 8'hA5);
    apb_read(32'h14, d); check("bad_addr_data", d, 32'h0);

    // Software reset with PW=4
    apb_write(32'h00, 32'h0000_0401, 4'hF);
    check("sw_periph", periph_rst_o, 8'hFF);
    check("sw_clk_en", clk_en_o, 8'h00);
    count_pulse(n); check("sw_pulse_len", n, 4);
    apb_read(32'h10, d); check("stat_sw", d, 32'h9);
    apb_write(32'h10, 32'h8, 4'hF);
    apb_read(32'h10, d); check("stat_sw_clr", d, 32'h1);

    // Watchdog then external request, extending the pulse
    wdt_rst_req_i = 1;
    n = 0;
    while (sys_rst_o !== 1'b1 && n < 10) begin tick(); n++; end
    check("wdt_rise", sys_rst_o, 1'b1);
    n = 1;
    tick(); n += int'(sys_rst_o);
    tick(); n += int'(sys_rst_o);
    ext_rst_req_i = 1;
    tick();
    count_pulse(ones); n += ones;
    check("extended_len", n, 8);
    ext_rst_req_i = 0; wdt_rst_req_i = 0;
    apb_read(32'h10, d); check("stat_ext_wdt", d, 32'h7);

    // Trigger set wins over a W1C of the same bit
    apb_write(32'h10, 32'h6, 4'hF);
    apb_read(32'h10, d); check("stat_cleared", d, 32'h1);
    wdt_rst_req_i = 1;
    apb_write(32'h10, 32'h4, 4'hF);
    apb_read(32'h10, d); check("set_beats_clr", d, 32'h5);
    wdt_rst_req_i = 0;
    count_pulse(n);

    // Divider
    apb_write(32'h0C, 32'h3, 4'hF);
    ones = 0;
    for (int i = 0; i < 8; i++) begin ones += int'(clkdiv_en_o); tick(); end
    check("div3_ones", ones, HAS_DIV ? 2 : 8);
    apb_read(32'h0C, d); check("div_readback", d, HAS_DIV ? 32'h3 : 32'h0);
    apb_write(32'h0C, 32'h0, 4'hF);
    ones = 0;
    for (int i = 0; i < 8; i++) begin ones += int'(clkdiv_en_o); tick(); end
    check("div0_ones", ones, 8);

    // PW=0 gives a single-cycle pulse; a byte-1 write changes only PW
    apb_write(32'h00, 32'h0000_0001, 4'hF);
    count_pulse(n); check("pw0_pulse_len", n, 1);
    apb_write(32'h00, 32'h0000_0501, 4'h2);
    check("strb_no_swrst", sys_rst_o, 1'b0);
    apb_read(32'h00, d); check("strb_pw_only", d, 32'h500);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 11) == 0) ext_rst_req_i = ~ext_rst_req_i;
      if ($urandom_range(0, 11) == 0) wdt_rst_req_i = ~wdt_rst_req_i;
      if (it == 200) begin
        rst_i = 1; tick(); tick(); rst_i = 0;
      end
      op = $urandom_range(0, 9);
      a  = $urandom;
      wd = $urandom;
      if (a[4:2] == 3'd0) wd = wd & 32'hFFFF_07FF;
      if (a[4:2] == 3'd3) wd = wd & 32'h7;
      if (op < 4)      apb_write(a, wd, 4'($urandom_range(0, 15)));
      else if (op < 7) apb_read(a, d);
      else             tick();
    end
    ext_rst_req_i = 0; wdt_rst_req_i = 0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
